downstream_ram_ctrl: RTL



---
 rtl/downstream_ram_ctrl_pkg.sv | 28 ++
 rtl/downstream_ram_ctrl_arb.sv | 27 ++
 rtl/downstream_ram_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/downstream_ram_ctrl_pkg.sv
// Shared types and constants for the cache / downstream RAM datapath.
// Holds the downstream controller state encoding and helpers.
package cache_def;

   localparam int DOWN_IDX_W  = 5;
   localparam int DOWN_AMT_W  = 16;
   localparam int DOWN_LINE_W = 128;

   typedef struct packed {
      logic [9:0] rdindex;
      logic [9:0] wrindex;
      logic       we;
   } cache_req_type;

   typedef logic [127:0] cache_data_type;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      RESP
   } down_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/downstream_ram_ctrl_arb.sv
// Two-requester round-robin arbiter; requester a (update) is favoured out of reset.
module down_rr_arb (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   logic rr_ptr;

   always_comb begin
      gnt_a = en && req_a && (!req_b || !rr_ptr);
      gnt_b = en && req_b && (!req_a ||  rr_ptr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 1'b0;
      end else if (gnt_a || gnt_b) begin
         rr_ptr <= ~rr_ptr;
      end
   end

endmodule

// File: rtl/downstream_ram_ctrl.sv
// Serialising controller for the downstream cancelled-orders RAM.
// Define DOWNSTREAM_ACCUM_EN for read-modify-write (saturating accumulate) updates.
module downstream_ram_ctrl
   import cache_def::*;
#(
   parameter int IDX_W  = DOWN_IDX_W,
   parameter int AMT_W  = DOWN_AMT_W,
   parameter int LINE_W = DOWN_LINE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              upd_valid,
   output logic              upd_ready,
   input  logic [IDX_W-1:0]  upd_client,
   input  logic [AMT_W-1:0]  upd_amount,
   input  logic              qry_valid,
   output logic              qry_ready,
   input  logic [IDX_W-1:0]  qry_client,
   output logic              rsp_valid,
   output logic [IDX_W-1:0]  rsp_client,
   output logic [AMT_W-1:0]  rsp_amount,
   output cache_req_type     ram_req,
   output logic [LINE_W-1:0] ram_wdata,
   input  logic [LINE_W-1:0] ram_rdata,
   output logic [15:0]       stat_writes,
   output logic [15:0]       stat_skipped
);

   down_state_e       state, state_nxt;
   logic              gnt_upd, gnt_qry;
   logic              is_dup;
   logic [IDX_W-1:0]  cap_client;
   logic [AMT_W-1:0]  cap_amount;
   logic              unused_rdata;

   assign unused_rdata = ^ram_rdata[LINE_W-1:AMT_W];

   down_rr_arb u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state == IDLE),
      .req_a (upd_valid),
      .req_b (qry_valid),
      .gnt_a (gnt_upd),
      .gnt_b (gnt_qry)
   );

`ifdef DOWNSTREAM_ACCUM_EN
   logic             cap_is_upd;
   logic [AMT_W:0]   acc_sum;

   assign is_dup  = 1'b0;
   assign acc_sum = {1'b0, ram_rdata[AMT_W-1:0]} + {1'b0, cap_amount};
`else
   logic             last_vld;
   logic [IDX_W-1:0] last_client;
   logic [AMT_W-1:0] last_amount;

   assign is_dup = last_vld && (upd_client == last_client) && (upd_amount == last_amount);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
`ifdef DOWNSTREAM_ACCUM_EN
            if (gnt_upd)                  state_nxt = READ;
`else
            if (gnt_upd && !is_dup)       state_nxt = WRITE;
`endif
            else if (gnt_qry)             state_nxt = READ;
         end
         WRITE: state_nxt = IDLE;
         READ:  state_nxt = RESP;
         RESP: begin
`ifdef DOWNSTREAM_ACCUM_EN
            state_nxt = cap_is_upd ? WRITE : IDLE;
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      upd_ready  = gnt_upd;
      qry_ready  = gnt_qry;
      ram_req    = '0;
      ram_req.wrindex[IDX_W-1:0] = cap_client;
      ram_req.we = (state == WRITE);
      ram_wdata  = '0;
      ram_wdata[AMT_W-1:0] = cap_amount;
`ifdef DOWNSTREAM_ACCUM_EN
      rsp_valid  = (state == RESP) && !cap_is_upd;
`else
      rsp_valid  = (state == RESP);
`endif
      rsp_client = rsp_valid ? cap_client : '0;
      rsp_amount = rsp_valid ? ram_rdata[AMT_W-1:0] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_client   <= '0;
         cap_amount   <= '0;
         stat_writes  <= '0;
         stat_skipped <= '0;
`ifdef DOWNSTREAM_ACCUM_EN
         cap_is_upd   <= 1'b0;
`else
         last_vld     <= 1'b0;
         last_client  <= '0;
         last_amount  <= '0;
`endif
      end else begin
         if (gnt_upd && !is_dup) begin
            cap_client <= upd_client;
            cap_amount <= upd_amount;
`ifdef DOWNSTREAM_ACCUM_EN
            cap_is_upd <= 1'b1;
`endif
         end
         if (gnt_qry) begin
            cap_client <= qry_client;
`ifdef DOWNSTREAM_ACCUM_EN
            cap_is_upd <= 1'b0;
`endif
         end
         if (gnt_upd && is_dup) begin
            stat_skipped <= sat_inc16(stat_skipped);
         end
         if (state == WRITE) begin
            stat_writes <= sat_inc16(stat_writes);
`ifndef DOWNSTREAM_ACCUM_EN
            last_vld    <= 1'b1;
            last_client <= cap_client;
            last_amount <= cap_amount;
`endif
         end
`ifdef DOWNSTREAM_ACCUM_EN
         // Old value arrives in RESP; fold the sum back into cap_amount for WRITE.
         if (state == RESP && cap_is_upd) begin
            cap_amount <= acc_sum[AMT_W] ? '1 : acc_sum[AMT_W-1:0];
         end
`endif
      end
   end

endmodule
